mem_arbiter: RTL

Arbitrates a single synchronous single-port data memory between two requesters: the core's multicycle memory interface (instruction fetch and load/store) and the program loader (UART boot loader). It sits between both requesters and the memory macro. It issues at most one access per cycle and returns read data to the requester that issued each read, after a fixed memory latency. It replaces the fixed wait-state assumption in the core's control FSM with a grant/valid handshake.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/rd_tag_pipe.sv | 30 +++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_pkg - shared types and default widths for mem_arbiter (rev 1.0)
// ---------------------------------------------------------------------------
package mem_pkg;

  localparam int MEM_ADDR_W = 15;
  localparam int MEM_DATA_W = 32;

  typedef enum logic {
    OWN_CORE   = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  typedef enum logic [0:0] {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/rd_tag_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rd_tag_pipe - DEPTH-stage {valid, owner} shift register, sync clear (rev 1.0)
// ---------------------------------------------------------------------------
module rd_tag_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t tags_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tags_q[i] <= '0;
    end else begin
      tags_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) tags_q[i] <= tags_q[i-1];
    end
  end

  assign tag_o = tags_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter - round-robin core/loader arbiter for a single-port memory.
// Optional loader lock when MEMARB_LOCK_EN is defined. (rev 1.0)
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  input  logic              l_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  owner_e  prio_q, prio_d;
  logic    w_locked;
  rd_tag_t w_tag_in, w_tag_out;

`ifdef MEMARB_LOCK_EN
  lock_state_e lk_state_q, lk_state_d;

  always_ff @(posedge clk) begin
    if (rst) lk_state_q <= LK_IDLE;
    else     lk_state_q <= lk_state_d;
  end

  always_comb begin
    lk_state_d = lk_state_q;
    case (lk_state_q)
      LK_IDLE:   if (l_lock && l_gnt) lk_state_d = LK_LOCKED;
      LK_LOCKED: if (!l_lock)         lk_state_d = LK_IDLE;
    endcase
  end

  always_comb w_locked = (lk_state_q == LK_LOCKED);
`else
  logic w_lock_unused;
  assign w_lock_unused = l_lock;
  assign w_locked      = 1'b0;
`endif

  always_comb begin
    c_gnt = 1'b0;
    l_gnt = 1'b0;
    if (w_locked) begin
      l_gnt = l_req;
    end else if (c_req && l_req) begin
      c_gnt = (prio_q == OWN_CORE);
      l_gnt = (prio_q == OWN_LOADER);
    end else begin
      c_gnt = c_req;
      l_gnt = l_req;
    end
  end

  // Round-robin: the side just served loses priority to the other one.
  always_comb begin
    prio_d = prio_q;
    if (c_gnt)      prio_d = OWN_LOADER;
    else if (l_gnt) prio_d = OWN_CORE;
  end

  always_ff @(posedge clk) begin
    if (rst) prio_q <= OWN_CORE;
    else     prio_q <= prio_d;
  end

  assign mem_en = c_gnt | l_gnt;

  always_comb begin
    if (l_gnt) begin
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end else begin
      mem_we    = c_gnt & c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end
  end

  always_comb begin
    w_tag_in.valid = mem_en & ~mem_we;
    w_tag_in.owner = l_gnt ? OWN_LOADER : OWN_CORE;
  end

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (w_tag_in),
    .tag_o (w_tag_out)
  );

  // A tag leaving the pipe during reset belongs to a discarded read.
  assign c_rvalid = ~rst & w_tag_out.valid & (w_tag_out.owner == OWN_CORE);
  assign l_rvalid = ~rst & w_tag_out.valid & (w_tag_out.owner == OWN_LOADER);
  assign c_rdata  = mem_rdata;
  assign l_rdata  = mem_rdata;

endmodule
`default_nettype wire
